fft_mag_buf: RTL and testbench

Post-FFT spectrum stage. Consumes the complex bin stream from the radix-2 FFT output port (one complex bin per valid cycle, SIZE/2 bins per frame), computes an alpha-max-plus-beta-min magnitude per bin through a 3-stage pipeline, and writes it into a double-buffered spectrum RAM. The display/readout side reads only the last completed frame, and the bank swap is signalled by `frame_done`.

---
 rtl/fft_pkg.sv | 17 +
 rtl/spectrum_ram.sv | 28 ++
 rtl/fft_mag_buf.sv | 168 ++++++++++++++++
 tb/tb_fft_mag_buf.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg -- shared definitions for the post-FFT spectrum stage.
//   mag_w(rn) : unsigned magnitude width for signed rn-bit components.
//               |x| of an rn-bit signed value needs rn bits. Adding the
//               alpha-max-plus-beta-min terms (at most 1.375*hi) needs one more.
// The bin index type and the pipeline entry struct depend on the instance
// parameters. They are declared in fft_mag_buf using these helpers.
package fft_pkg;

    function automatic int mag_w(input int rn);
        return rn + 1;
    endfunction

    function automatic int bin_w(input int size);
        return $clog2(size / 2);
    endfunction

endpackage

// File: rtl/spectrum_ram.sv
// spectrum_ram -- simple dual-port RAM with a registered read port (inferred).
//   clk           : clock
//   we/waddr/wdata: write port, written at the clock edge
//   raddr/rdata   : read port, rdata valid one cycle after raddr
// Contents are not reset.
module spectrum_ram #(
    parameter int AW = 10,
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fft_mag_buf.sv
// fft_mag_buf -- per-bin magnitude of the FFT output stream, double-buffered.
//   clk, reset          : single clock, synchronous active-high reset
//   in_valid, in[0..1]  : complex bin stream (real, imag), signed RN bits
//   mag_valid/mag/mag_bin : 3-cycle magnitude pipeline output
//   frame_done          : one-cycle pulse when a full frame has been banked
//   rd_addr -> rd_data  : 1-cycle readout of the last completed frame
//   peak_mag/peak_bin   : largest non-DC bin of the last frame
//                         (present only when FFT_MAG_PEAK_EN is defined)
// Magnitude uses hi + lo/4 + lo/8, where hi = max(|re|,|im|) and lo = min(|re|,|im|).
module fft_mag_buf
    import fft_pkg::*;
#(
    parameter  int SIZE  = 1024,
    parameter  int RN    = 16,
    localparam int NB    = SIZE / 2,
    localparam int SIZEN = bin_w(SIZE),
    localparam int MN    = mag_w(RN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [1:0][RN-1:0]   in,
    output logic                 mag_valid,
    output logic [MN-1:0]        mag,
    output logic [SIZEN-1:0]     mag_bin,
    output logic                 frame_done,
`ifdef FFT_MAG_PEAK_EN
    output logic [MN-1:0]        peak_mag,
    output logic [SIZEN-1:0]     peak_bin,
`endif
    input  logic [SIZEN-1:0]     rd_addr,
    output logic [MN-1:0]        rd_data
);

    typedef logic [SIZEN-1:0] bin_t;

    // Stage 0 holds signed re/im. Stage 1 reuses the same fields for |re|/|im|.
    typedef struct packed {
        logic          valid;
        logic          last;
        bin_t          bin;
        logic [RN-1:0] re;
        logic [RN-1:0] im;
    } entry_t;

    entry_t        s0_q, s0_d, s1_q, s1_d;
    bin_t          bin_in_q, bin_in_d;
    logic          mag_valid_q, mag_valid_d;
    logic          last2_q, last2_d;
    logic [MN-1:0] mag_q, mag_d;
    bin_t          mag_bin_q, mag_bin_d;
    logic          frame_done_q, frame_done_d;
    logic          wr_bank_q, wr_bank_d;
    logic [RN-1:0] hi, lo;

    always_comb begin
        // Any idle cycle restarts the bin count, so every burst begins at bin 0.
        bin_in_d = '0;
        if (in_valid) bin_in_d = (bin_in_q == bin_t'(NB-1)) ? '0 : bin_in_q + bin_t'(1);

        s0_d.valid = in_valid;
        s0_d.last  = in_valid && (bin_in_q == bin_t'(NB-1));
        s0_d.bin   = bin_in_q;
        s0_d.re    = in[0];
        s0_d.im    = in[1];

        // Negation of -2^(RN-1) wraps to 2^(RN-1). Read as unsigned, that is exact.
        s1_d    = s0_q;
        s1_d.re = s0_q.re[RN-1] ? -s0_q.re : s0_q.re;
        s1_d.im = s0_q.im[RN-1] ? -s0_q.im : s0_q.im;

        hi = (s1_q.re >= s1_q.im) ? s1_q.re : s1_q.im;
        lo = (s1_q.re >= s1_q.im) ? s1_q.im : s1_q.re;

        mag_valid_d = s1_q.valid;
        last2_d     = s1_q.valid && s1_q.last;
        mag_d       = mag_q;
        mag_bin_d   = mag_bin_q;
        if (s1_q.valid) begin
            mag_d     = MN'(hi) + MN'(lo >> 2) + MN'(lo >> 3);
            mag_bin_d = s1_q.bin;
        end

        // Swap banks on the edge that completes the write of the last bin.
        frame_done_d = mag_valid_q && last2_q;
        wr_bank_d    = wr_bank_q ^ frame_done_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q         <= '0;
            s1_q         <= '0;
            bin_in_q     <= '0;
            mag_valid_q  <= 1'b0;
            last2_q      <= 1'b0;
            mag_q        <= '0;
            mag_bin_q    <= '0;
            frame_done_q <= 1'b0;
            wr_bank_q    <= 1'b0;
        end else begin
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            bin_in_q     <= bin_in_d;
            mag_valid_q  <= mag_valid_d;
            last2_q      <= last2_d;
            mag_q        <= mag_d;
            mag_bin_q    <= mag_bin_d;
            frame_done_q <= frame_done_d;
            wr_bank_q    <= wr_bank_d;
        end
    end

    // Gating with reset keeps an entry that is in flight from landing after reset asserts.
    spectrum_ram #(.AW(SIZEN + 1), .DW(MN)) u_ram (
        .clk   (clk),
        .we    (mag_valid_q && !reset),
        .waddr ({wr_bank_q, mag_bin_q}),
        .wdata (mag_q),
        .raddr ({~wr_bank_q, rd_addr}),
        .rdata (rd_data)
    );

    assign mag_valid  = mag_valid_q;
    assign mag        = mag_q;
    assign mag_bin    = mag_bin_q;
    assign frame_done = frame_done_q;

`ifdef FFT_MAG_PEAK_EN
    logic [MN-1:0] run_mag_q, run_mag_d, peak_mag_q, peak_mag_d;
    bin_t          run_bin_q, run_bin_d, peak_bin_q, peak_bin_d;

    always_comb begin
        run_mag_d = run_mag_q;
        run_bin_d = run_bin_q;
        // Bin 1 seeds the max, which excludes DC. Strict > lets the lowest bin win a tie.
        if (mag_valid_q && (mag_bin_q == bin_t'(1) ||
                            (mag_bin_q > bin_t'(1) && mag_q > run_mag_q))) begin
            run_mag_d = mag_q;
            run_bin_d = mag_bin_q;
        end
        // Latch together with frame_done so the last bin is included.
        peak_mag_d = peak_mag_q;
        peak_bin_d = peak_bin_q;
        if (frame_done_d) begin
            peak_mag_d = run_mag_d;
            peak_bin_d = run_bin_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_mag_q  <= '0;
            run_bin_q  <= '0;
            peak_mag_q <= '0;
            peak_bin_q <= '0;
        end else begin
            run_mag_q  <= run_mag_d;
            run_bin_q  <= run_bin_d;
            peak_mag_q <= peak_mag_d;
            peak_bin_q <= peak_bin_d;
        end
    end

    assign peak_mag = peak_mag_q;
    assign peak_bin = peak_bin_q;
`endif

endmodule

// File: tb/tb_fft_mag_buf.sv
// tb_fft_mag_buf -- directed checks of fft_mag_buf with SIZE=16 (NB=8), RN=16.
module tb_fft_mag_buf;

    localparam int SIZE  = 16;
    localparam int RN    = 16;
    localparam int SIZEN = 3;
    localparam int MN    = 17;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic [1:0][RN-1:0]   in_d = '0;
    logic [SIZEN-1:0]     rd_addr = '0;
    logic                 mag_valid;
    logic [MN-1:0]        mag;
    logic [SIZEN-1:0]     mag_bin;
    logic                 frame_done;
    logic [MN-1:0]        rd_data;
`ifdef FFT_MAG_PEAK_EN
    logic [MN-1:0]        peak_mag;
    logic [SIZEN-1:0]     peak_bin;
`endif

    fft_mag_buf #(.SIZE(SIZE), .RN(RN)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in         (in_d),
        .mag_valid  (mag_valid),
        .mag        (mag),
        .mag_bin    (mag_bin),
        .frame_done (frame_done),
`ifdef FFT_MAG_PEAK_EN
        .peak_mag   (peak_mag),
        .peak_bin   (peak_bin),
`endif
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output log: sampled on the falling edge.
    int fd_cnt = 0;
    int fd_cyc[$];
    int mq_cyc[$];
    int mq_bin[$];
    int mq_mag[$];

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc.push_back(cyc);
        end
        if (mag_valid === 1'b1) begin
            mq_cyc.push_back(cyc);
            mq_bin.push_back(int'(mag_bin));
            mq_mag.push_back(int'(mag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int re, input int im);
        in_valid = v;
        in_d[0]  = re[RN-1:0];
        in_d[1]  = im[RN-1:0];
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
    endtask

    task automatic clear_log();
        mq_cyc.delete();
        mq_bin.delete();
        mq_mag.delete();
    endtask

    // Returns the cycle in which frame_done is seen high, or -1 after a bounded wait.
    task automatic wait_fd(output int c);
        c = -1;
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (frame_done === 1'b1) begin
                c = cyc;
                break;
            end
            tick();
        end
        if (c < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL fd_timeout: got no frame_done expected a pulse");
        end
    endtask

    task automatic rd(input int a, input int exp, input string tag);
        rd_addr = a[SIZEN-1:0];
        tick();
        chk(tag, rd_data, exp);
    endtask

    initial begin
        int t0, c, fd0, n0;

        // reset state
        idle(3);
        chk("rst_mag_valid", mag_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_mag", mag, 0);
        chk("rst_mag_bin", mag_bin, 0);
        reset = 1'b0;
        idle(2);

        // magnitude values and latency, as a 4-bin partial burst
        clear_log();
        t0 = cyc;
        drive(1'b1, 300, -400);
        drive(1'b1, -32768, 0);
        drive(1'b1, 0, 0);
        drive(1'b1, -5, -5);
        idle(6);
        chk("mag_count", mq_mag.size(), 4);
        chk("mag_latency", mq_cyc[0], t0 + 3);
        chk("mag_300_m400", mq_mag[0], 512);
        chk("mag_m32768", mq_mag[1], 32768);
        chk("mag_zero", mq_mag[2], 0);
        chk("mag_m5_m5", mq_mag[3], 6);
        chk("mag_bin3", mq_bin[3], 3);
        chk("partial_no_fd", fd_cnt, 0);

        // one full frame, bin k = (100k, 0)
        clear_log();
        for (int k = 0; k < 8; k++) drive(1'b1, 100 * k, 0);
        t0 = cyc - 1;
        wait_fd(c);
        chk("fd_latency", c, t0 + 4);
        rd(3, 300, "rd_in_fd_cycle_bin3");
        rd(7, 700, "rd_bin7");
        idle(4);
        chk("full_fd_count", fd_cnt, 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("frame_bin%0d", k), mq_bin[k], k);
            chk($sformatf("frame_mag%0d", k), mq_mag[k], 100 * k);
        end

        // partial frame of 5 bins, gap, full frame
        fd0 = fd_cnt;
        clear_log();
        for (int k = 0; k < 5; k++) drive(1'b1, 50 + k, 0);
        drive(1'b0, 0, 0);
        for (int k = 0; k < 8; k++) drive(1'b1, 1000 + 10 * k, 0);
        wait_fd(c);
        idle(4);
        chk("pf_fd_count", fd_cnt - fd0, 1);
        chk("pf_log_count", mq_mag.size(), 13);
        chk("pf_partial_bin4", mq_bin[4], 4);
        chk("pf_restart_bin0", mq_bin[5], 0);
        chk("pf_last_bin7", mq_bin[12], 7);
        rd(2, 1020, "pf_rd_bin2");
        rd(4, 1040, "pf_rd_bin4_overwritten");
        rd(6, 1060, "pf_rd_bin6");

        // two back-to-back frames
        fd0 = fd_cnt;
        n0  = fd_cyc.size();
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 8; k++) drive(1'b1, (f == 0 ? 7 : 13) * (k + 1), 0);
        idle(8);
        chk("b2b_fd_count", fd_cnt - fd0, 2);
        chk("b2b_fd_spacing", fd_cyc[n0 + 1] - fd_cyc[n0], 8);
        rd(4, 65, "b2b_rd_bin4");
        rd(0, 13, "b2b_rd_bin0");

`ifdef FFT_MAG_PEAK_EN
        // peak: DC excluded, the earlier bin wins the tie
        for (int k = 0; k < 8; k++)
            drive(1'b1, (k == 0) ? 5000 : ((k == 2 || k == 5) ? 900 : 0), 0);
        wait_fd(c);
        tick();
        chk("peak_mag", peak_mag, 900);
        chk("peak_bin", peak_bin, 2);
        idle(2);
`endif

        // reset asserted at bin 4, then a full frame
        fd0 = fd_cnt;
        for (int k = 0; k < 4; k++) drive(1'b1, 1, 0);
        reset = 1'b1;
        drive(1'b1, 1, 0);
        idle(2);
        chk("rstmid_mag_valid", mag_valid, 0);
        chk("rstmid_mag", mag, 0);
        chk("rstmid_mag_bin", mag_bin, 0);
        chk("rstmid_frame_done", frame_done, 0);
        reset = 1'b0;
        idle(6);
        chk("rstmid_no_fd", fd_cnt - fd0, 0);
        for (int k = 0; k < 8; k++) drive(1'b1, 0, 3 * (k + 1));
        wait_fd(c);
        idle(4);
        chk("rstmid_fd_count", fd_cnt - fd0, 1);
        rd(5, 18, "rstmid_rd_bin5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
